timer_controller: RTL and testbench

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_controller.sv | 155 +++++++++++++++
 tb/tb_timer_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// -----------------------------------------------------------------------------
// timer_controller
//   Prescaled up/down timer with period-end interrupt, compare match pulse and
//   PWM output. Runs in continuous (auto-reload) or one-shot mode.
//
// Ports
//   clk        in   1          single clock, rising edge
//   rst        in   1          synchronous reset, active-low
//   start      in   1          pulse: arm and start (IDLE/DONE only)
//   stop       in   1          pulse: halt (RUN only); beats a coincident start
//   one_shot   in   1          1 = single period, 0 = continuous
//   count_up   in   1          1 = count up, 0 = count down
//   prescale   in   PRE_WIDTH  one tick every prescale+1 cycles
//   top        in   WIDTH      period end value (used live)
//   compare    in   WIDTH      compare / PWM threshold (used live)
//   irq_clear  in   1          clears the sticky irq flag
//   value      out  WIDTH      registered counter value
//   running    out  1          state is RUN
//   done       out  1          state is DONE
//   match      out  1          one-cycle pulse after a tick landing on compare
//   pwm        out  1          registered (RUN && value < compare)
//   irq        out  1          sticky period-end flag
// -----------------------------------------------------------------------------
module timer_controller #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 one_shot,
  input  logic                 count_up,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]     top,
  input  logic [WIDTH-1:0]     compare,
  input  logic                 irq_clear,
  output logic [WIDTH-1:0]     value,
  output logic                 running,
  output logic                 done,
  output logic                 match,
  output logic                 pwm,
  output logic                 irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_value;
  logic [WIDTH-1:0]     w_value_nxt;
  logic [PRE_WIDTH-1:0] r_pre;
  logic [PRE_WIDTH-1:0] w_pre_nxt;
  logic                 r_one_shot;
  logic                 w_one_shot_nxt;
  logic                 r_count_up;
  logic                 w_count_up_nxt;
  logic [PRE_WIDTH-1:0] r_prescale;
  logic [PRE_WIDTH-1:0] w_prescale_nxt;
  logic                 r_match;
  logic                 w_match_nxt;
  logic                 r_pwm;
  logic                 w_pwm_nxt;
  logic                 r_irq;
  logic                 w_irq_nxt;

  logic                 w_tick;
  logic                 w_period_end;

  // A stop in RUN suppresses the tick of that cycle: the counter freezes.
  assign w_tick       = (r_state == S_RUN) && !stop && (r_pre == r_prescale);
  assign w_period_end = w_tick &&
                        (r_count_up ? (r_value == top) : (r_value == '0));

  always_comb begin
    w_state_nxt    = r_state;
    w_value_nxt    = r_value;
    w_pre_nxt      = r_pre;
    w_one_shot_nxt = r_one_shot;
    w_count_up_nxt = r_count_up;
    w_prescale_nxt = r_prescale;

    case (r_state)
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
          if (w_period_end) begin
            // One-shot holds the final value; continuous reloads.
            if (r_one_shot) w_state_nxt = S_DONE;
            else            w_value_nxt = r_count_up ? '0 : top;
          end else if (w_tick) begin
            // Plain modulo step: a top lowered below value is reached only
            // after wrapping through all-ones.
            w_value_nxt = r_count_up ? r_value + 1'b1 : r_value - 1'b1;
          end
        end
      end
      default: begin
        if (start && !stop) begin
          w_state_nxt    = S_RUN;
          w_one_shot_nxt = one_shot;
          w_count_up_nxt = count_up;
          w_prescale_nxt = prescale;
          w_value_nxt    = count_up ? '0 : top;
          w_pre_nxt      = '0;
        end
      end
    endcase

    // Gated on the next state so a one-shot finishing tick never shows
    // match or pwm while in DONE.
    w_match_nxt = w_tick && (w_state_nxt == S_RUN) && (w_value_nxt == compare);
    w_pwm_nxt   = (w_state_nxt == S_RUN) && (w_value_nxt < compare);
    // Set wins over clear.
    w_irq_nxt   = w_period_end ? 1'b1 : (irq_clear ? 1'b0 : r_irq);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_value    <= '0;
      r_pre      <= '0;
      r_one_shot <= 1'b0;
      r_count_up <= 1'b1;
      r_prescale <= '0;
      r_match    <= 1'b0;
      r_pwm      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_value    <= w_value_nxt;
      r_pre      <= w_pre_nxt;
      r_one_shot <= w_one_shot_nxt;
      r_count_up <= w_count_up_nxt;
      r_prescale <= w_prescale_nxt;
      r_match    <= w_match_nxt;
      r_pwm      <= w_pwm_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  assign value   = r_value;
  assign running = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign match   = r_match;
  assign pwm     = r_pwm;
  assign irq     = r_irq;

endmodule

// File: tb/tb_timer_controller.sv
module tb_timer_controller;

  localparam int W   = 8;
  localparam int PW  = 4;
  localparam int MOD = 1 << W;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          one_shot;
  logic          count_up;
  logic [PW-1:0] prescale;
  logic [W-1:0]  top;
  logic [W-1:0]  compare;
  logic          irq_clear;
  logic [W-1:0]  value;
  logic          running;
  logic          done;
  logic          match;
  logic          pwm;
  logic          irq;

  timer_controller #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
    .count_up(count_up), .prescale(prescale), .top(top), .compare(compare),
    .irq_clear(irq_clear), .value(value), .running(running), .done(done),
    .match(match), .pwm(pwm), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit use_model = 0;

  // Reference model: timer described as "cycles since last tick" and plain
  // integer arithmetic modulo 2^W. m_state: 0 idle, 1 run, 2 done.
  int m_state, m_val, m_cnt, m_pre;
  bit m_os, m_up, m_match, m_pwm, m_irq;

  task automatic model_step();
    bit tick;
    bit pend;
    tick = 0;
    pend = 0;
    if (!rst) begin
      m_state = 0; m_val = 0; m_cnt = 0; m_pre = 0; m_os = 0; m_up = 1;
      m_match = 0; m_pwm = 0; m_irq = 0;
      return;
    end
    if (m_state == 1 && stop) begin
      m_state = 0;
    end else if (m_state != 1 && start && !stop) begin
      m_os = one_shot; m_up = count_up; m_pre = int'(prescale);
      m_val = count_up ? 0 : int'(top);
      m_cnt = 0; m_state = 1;
    end else if (m_state == 1) begin
      m_cnt++;
      if (m_cnt > m_pre) begin
        tick  = 1;
        m_cnt = 0;
        pend  = m_up ? (m_val == int'(top)) : (m_val == 0);
        if (pend) begin
          if (m_os) m_state = 2;
          else      m_val = m_up ? 0 : int'(top);
        end else begin
          m_val = (m_val + (m_up ? 1 : MOD - 1)) % MOD;
        end
      end
    end
    m_match = tick && (m_state == 1) && (m_val == int'(compare));
    m_pwm   = (m_state == 1) && (m_val < int'(compare));
    if (pend) m_irq = 1;
    else if (irq_clear) m_irq = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (use_model) begin
      chk("model.value",   {24'd0, value}, 32'(m_val));
      chk("model.running", {31'd0, running}, {31'd0, m_state == 1});
      chk("model.done",    {31'd0, done},    {31'd0, m_state == 2});
      chk("model.match",   {31'd0, match},   {31'd0, m_match});
      chk("model.pwm",     {31'd0, pwm},     {31'd0, m_pwm});
      chk("model.irq",     {31'd0, irq},     {31'd0, m_irq});
    end
  endtask

  task automatic set_in(input bit st, input bit sp, input bit os, input bit up,
                        input int pr, input int tp, input int cp, input bit cl);
    start = st; stop = sp; one_shot = os; count_up = up;
    prescale = PW'(pr); top = W'(tp); compare = W'(cp); irq_clear = cl;
  endtask

  task automatic do_reset();
    rst = 0;
    set_in(0, 0, 0, 1, 0, 0, 0, 0);
    step();
    rst = 1;
  endtask

  typedef struct {
    int r, st, sp, os, up, pr, tp, cp, cl;
    int ev, er, ed, em, ep, ei;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input int r, input int st, input int sp, input int os,
                      input int up, input int pr, input int tp, input int cp,
                      input int cl, input int ev, input int er, input int ed,
                      input int em, input int ep, input int ei);
    vec_t v;
    v = '{r, st, sp, os, up, pr, tp, cp, cl, ev, er, ed, em, ep, ei};
    vecs.push_back(v);
  endtask

  initial begin
    rst = 0;
    set_in(0, 0, 0, 1, 0, 0, 0, 0);

    //    rst st sp os up pr tp cp cl | val run done match pwm irq
    addv(0, 0, 0, 0, 1, 0, 3, 2, 0,   0, 0, 0, 0, 0, 0);
    addv(1, 1, 0, 0, 1, 0, 3, 2, 0,   0, 1, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 0,   1, 1, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 0,   2, 1, 0, 1, 0, 0);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 0,   3, 1, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 0,   0, 1, 0, 0, 1, 1);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 1,   1, 1, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 0,   2, 1, 0, 1, 0, 0);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 0,   3, 1, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 1,   0, 1, 0, 0, 1, 1);
    addv(1, 0, 0, 0, 1, 0, 3, 2, 1,   1, 1, 0, 0, 1, 0);
    addv(1, 0, 1, 0, 1, 0, 3, 2, 0,   1, 0, 0, 0, 0, 0);
    addv(1, 1, 1, 0, 1, 0, 3, 2, 0,   1, 0, 0, 0, 0, 0);
    addv(1, 1, 0, 1, 0, 0, 2, 1, 0,   2, 1, 0, 0, 0, 0);
    addv(1, 0, 0, 1, 0, 0, 2, 1, 0,   1, 1, 0, 1, 0, 0);
    addv(1, 0, 0, 1, 0, 0, 2, 1, 0,   0, 1, 0, 0, 1, 0);
    addv(1, 0, 0, 1, 0, 0, 2, 1, 0,   0, 0, 1, 0, 0, 1);
    addv(1, 0, 1, 1, 0, 0, 2, 1, 0,   0, 0, 1, 0, 0, 1);
    addv(0, 0, 0, 1, 0, 0, 2, 1, 0,   0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = (vecs[i].r != 0);
      set_in(vecs[i].st != 0, vecs[i].sp != 0, vecs[i].os != 0, vecs[i].up != 0,
             vecs[i].pr, vecs[i].tp, vecs[i].cp, vecs[i].cl != 0);
      step();
      chk($sformatf("vec%0d.value", i),   {24'd0, value},   32'(vecs[i].ev));
      chk($sformatf("vec%0d.running", i), {31'd0, running}, 32'(vecs[i].er));
      chk($sformatf("vec%0d.done", i),    {31'd0, done},    32'(vecs[i].ed));
      chk($sformatf("vec%0d.match", i),   {31'd0, match},   32'(vecs[i].em));
      chk($sformatf("vec%0d.pwm", i),     {31'd0, pwm},     32'(vecs[i].ep));
      chk($sformatf("vec%0d.irq", i),     {31'd0, irq},     32'(vecs[i].ei));
    end

    use_model = 1;

    // Down, one-shot, prescale 2, top 5
    do_reset();
    set_in(1, 0, 1, 0, 2, 5, 0, 0);
    step();
    chk("down.start_value", {24'd0, value}, 32'd5);
    start = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk($sformatf("down.value_k%0d", k), {24'd0, value}, (k < 18) ? 32'(5 - k / 3) : 32'd0);
    end
    chk("down.done",    {31'd0, done},    32'd1);
    chk("down.running", {31'd0, running}, 32'd0);
    chk("down.irq",     {31'd0, irq},     32'd1);

    // Stop / start / reset mid-run
    do_reset();
    set_in(1, 0, 0, 1, 0, 20, 12, 0);
    step();
    start = 0;
    repeat (7) step();
    chk("stop.pre_value", {24'd0, value}, 32'd7);
    stop = 1;
    step();
    chk("stop.value_held", {24'd0, value},   32'd7);
    chk("stop.running",    {31'd0, running}, 32'd0);
    start = 1;
    step();
    chk("startstop.running", {31'd0, running}, 32'd0);
    chk("startstop.value",   {24'd0, value},   32'd7);
    stop = 0;
    step();
    chk("restart.value",   {24'd0, value},   32'd0);
    chk("restart.running", {31'd0, running}, 32'd1);
    start = 0;
    repeat (9) step();
    chk("rst.pre_value", {24'd0, value}, 32'd9);
    chk("rst.pre_pwm",   {31'd0, pwm},   32'd1);
    rst = 0;
    step();
    rst = 1;
    chk("rst.value",   {24'd0, value},   32'd0);
    chk("rst.running", {31'd0, running}, 32'd0);
    chk("rst.done",    {31'd0, done},    32'd0);
    chk("rst.match",   {31'd0, match},   32'd0);
    chk("rst.pwm",     {31'd0, pwm},     32'd0);
    chk("rst.irq",     {31'd0, irq},     32'd0);

    // top = 0, prescale 1: period end every 2 cycles; irq_clear held high
    do_reset();
    set_in(1, 0, 0, 1, 1, 0, 5, 1);
    step();
    start = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("top0.irq_k%0d", k),   {31'd0, irq},   {31'd0, (k % 2) == 0});
      chk($sformatf("top0.value_k%0d", k), {24'd0, value}, 32'd0);
    end
    stop = 1;
    step();
    stop = 0;
    one_shot = 1;
    start = 1;
    step();
    start = 0;
    step();
    chk("top0os.running", {31'd0, running}, 32'd1);
    step();
    chk("top0os.done", {31'd0, done}, 32'd1);
    chk("top0os.irq",  {31'd0, irq},  32'd1);

    // top lowered below value while counting up: wraps through all-ones
    do_reset();
    set_in(1, 0, 0, 1, 0, 10, 0, 0);
    step();
    start = 0;
    repeat (6) step();
    chk("wrap.value6", {24'd0, value}, 32'd6);
    top = W'(3);
    repeat (249) step();
    chk("wrap.value255", {24'd0, value}, 32'd255);
    step();
    chk("wrap.value0",  {24'd0, value},   32'd0);
    chk("wrap.irq0",    {31'd0, irq},     32'd0);
    chk("wrap.running", {31'd0, running}, 32'd1);
    repeat (3) step();
    chk("wrap.value3", {24'd0, value}, 32'd3);
    chk("wrap.irq3",   {31'd0, irq},   32'd0);
    step();
    chk("wrap.end_value", {24'd0, value}, 32'd0);
    chk("wrap.end_irq",   {31'd0, irq},   32'd1);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 31) == 0);
      one_shot  = ($urandom_range(0, 1) == 1);
      count_up  = ($urandom_range(0, 1) == 1);
      prescale  = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) top = W'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) compare = W'($urandom_range(0, 15));
      irq_clear = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
